// File: rtl/channel_in_tree_acc.sv
// Channel-in reduction: registered binary adder tree per picture lane, a first/last
// delimited accumulator, and an alignment delay line. Define TREE_ACC_SAT_EN for saturating adds.
module channel_in_tree_acc #(
  parameter int LANES = 2,
  parameter int LANE_W = 16,
  parameter int CH_NUM = 4,
  parameter int EXTRA_DELAY = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             valid_in,
  input  logic                             first_in,
  input  logic                             last_in,
  input  logic [LANES*CH_NUM*LANE_W-1:0]   data_in,
  output logic                             valid_out,
  output logic [LANES*LANE_W-1:0]          data_out,
  output logic                             proto_err
);

  localparam int L   = $clog2(CH_NUM);
  localparam int OW  = LANES * LANE_W;
  localparam int TW  = (CH_NUM - 1) * OW;
  localparam int TOP = (2*CH_NUM - 2) * OW;

  function automatic logic [LANE_W-1:0] add_lane(input logic [LANE_W-1:0] a,
                                                 input logic [LANE_W-1:0] b);
`ifdef TREE_ACC_SAT_EN
    logic [LANE_W:0] s;
    s = {a[LANE_W-1], a} + {b[LANE_W-1], b};
    if (s[LANE_W] != s[LANE_W-1])
      add_lane = s[LANE_W] ? {1'b1, {(LANE_W-1){1'b0}}} : {1'b0, {(LANE_W-1){1'b1}}};
    else
      add_lane = s[LANE_W-1:0];
`else
    add_lane = a + b;
`endif
  endfunction

  // Channel offset of tree level g inside lvl_all (level 0 is data_in itself).
  function automatic int lvl_base(input int g);
    return 2*CH_NUM - 2*(CH_NUM >> g);
  endfunction

  logic [TW-1:0]                 tree_d, tree_q;
  logic [L-1:0]                  tv_d, tv_q, tf_d, tf_q, tl_d, tl_q;
  logic [TW+CH_NUM*OW-1:0]       lvl_all;
  logic [OW-1:0]                 tree_sum;
  logic                          t_valid, t_first, t_last;
  logic [OW-1:0]                 acc_d, acc_q, res_d, res_q;
  logic                          open_d, open_q, err_d, err_q, res_v_d, res_v_q;

  assign lvl_all  = {tree_q, data_in};
  assign tree_sum = lvl_all[TOP +: OW];
  assign t_valid  = tv_q[L-1];
  assign t_first  = tf_q[L-1];
  assign t_last   = tl_q[L-1];

  always_comb begin
    tree_d = '0;
    for (int g = 0; g < L; g++)
      for (int k = 0; k < (CH_NUM >> (g+1)); k++)
        for (int p = 0; p < LANES; p++)
          tree_d[((lvl_base(g+1) - CH_NUM + k)*LANES + p)*LANE_W +: LANE_W] =
            add_lane(lvl_all[((lvl_base(g) + 2*k)*LANES + p)*LANE_W +: LANE_W],
                     lvl_all[((lvl_base(g) + 2*k + 1)*LANES + p)*LANE_W +: LANE_W]);
  end

  always_comb begin
    tv_d = '0;
    tf_d = '0;
    tl_d = '0;
    tv_d[0] = valid_in;
    tf_d[0] = first_in;
    tl_d[0] = last_in;
    for (int g = 1; g < L; g++) begin
      tv_d[g] = tv_q[g-1];
      tf_d[g] = tf_q[g-1];
      tl_d[g] = tl_q[g-1];
    end
  end

  // A first while open restarts the sum and flags an error; a non-first while closed just opens.
  always_comb begin
    acc_d   = acc_q;
    open_d  = open_q;
    err_d   = err_q;
    res_d   = res_q;
    res_v_d = 1'b0;
    if (t_valid) begin
      if (t_first || !open_q) begin
        acc_d = tree_sum;
        err_d = err_q | (t_first & open_q);
      end else begin
        for (int p = 0; p < LANES; p++)
          acc_d[p*LANE_W +: LANE_W] = add_lane(acc_q[p*LANE_W +: LANE_W],
                                               tree_sum[p*LANE_W +: LANE_W]);
      end
      open_d = ~t_last;
      if (t_last) begin
        res_d   = acc_d;
        res_v_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tree_q  <= '0;
      tv_q    <= '0;
      tf_q    <= '0;
      tl_q    <= '0;
      acc_q   <= '0;
      open_q  <= 1'b0;
      err_q   <= 1'b0;
      res_q   <= '0;
      res_v_q <= 1'b0;
    end else begin
      tree_q  <= tree_d;
      tv_q    <= tv_d;
      tf_q    <= tf_d;
      tl_q    <= tl_d;
      acc_q   <= acc_d;
      open_q  <= open_d;
      err_q   <= err_d;
      res_q   <= res_d;
      res_v_q <= res_v_d;
    end
  end

  assign proto_err = err_q;

  // valid_out is a one-cycle pulse per finished group; there is no backpressure, so data_out
  // is only meaningful on that pulse and otherwise holds the previous result.
  if (EXTRA_DELAY == 0) begin : gen_no_dly
    assign valid_out = res_v_q;
    assign data_out  = res_q;
  end else begin : gen_dly
    logic [OW-1:0]          dd_d [EXTRA_DELAY];
    logic [OW-1:0]          dd_q [EXTRA_DELAY];
    logic [EXTRA_DELAY-1:0] dv_d, dv_q;

    always_comb begin
      dv_d    = '0;
      dv_d[0] = res_v_q;
      dd_d[0] = res_v_q ? res_q : dd_q[0];
      for (int i = 1; i < EXTRA_DELAY; i++) begin
        dv_d[i] = dv_q[i-1];
        dd_d[i] = dv_q[i-1] ? dd_q[i-1] : dd_q[i];
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        dv_q <= '0;
        for (int i = 0; i < EXTRA_DELAY; i++) dd_q[i] <= '0;
      end else begin
        dv_q <= dv_d;
        for (int i = 0; i < EXTRA_DELAY; i++) dd_q[i] <= dd_d[i];
      end
    end

    assign valid_out = dv_q[EXTRA_DELAY-1];
    assign data_out  = dd_q[EXTRA_DELAY-1];
  end

endmodule

// File: tb/tb_channel_in_tree_acc.sv
// Directed bench for channel_in_tree_acc (LANES=2, LANE_W=16, CH_NUM=4, EXTRA_DELAY=3).
module tb_channel_in_tree_acc;

  logic         clk = 1'b0;
  logic         rst;
  logic         valid_in, first_in, last_in;
  logic [127:0] data_in;
  logic         valid_out;
  logic [31:0]  data_out;
  logic         proto_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_cyc;
  int last_cyc_q[$];
  logic [31:0] got_q[$];
  int          got_cyc_q[$];
  logic [31:0] exp_q[$];

  channel_in_tree_acc #(
    .LANES(2), .LANE_W(16), .CH_NUM(4), .EXTRA_DELAY(3)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .first_in(first_in), .last_in(last_in),
    .data_in(data_in), .valid_out(valid_out), .data_out(data_out), .proto_err(proto_err)
  );

  // clock / reset block
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // output monitor
  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      got_q.push_back(data_out);
      got_cyc_q.push_back(cyc);
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_in = 1'b0;
    first_in = 1'b0;
    last_in  = 1'b0;
    data_in  = '0;
  endtask

  task automatic drive(input logic f, input logic l,
                       input logic [15:0] a0, input logic [15:0] a1,
                       input logic [15:0] a2, input logic [15:0] a3,
                       input logic [15:0] b0, input logic [15:0] b1,
                       input logic [15:0] b2, input logic [15:0] b3);
    valid_in = 1'b1;
    first_in = f;
    last_in  = l;
    data_in  = {b3, a3, b2, a2, b1, a1, b0, a0};
    if (l) last_cyc_q.push_back(cyc);
  endtask

  task automatic send(input logic f, input logic l,
                      input logic [15:0] a0, input logic [15:0] a1,
                      input logic [15:0] a2, input logic [15:0] a3,
                      input logic [15:0] b0, input logic [15:0] b1,
                      input logic [15:0] b2, input logic [15:0] b3);
    tick();
    drive(f, l, a0, a1, a2, a3, b0, b1, b2, b3);
  endtask

  task automatic gap(input int n);
    repeat (n) begin
      tick();
      idle();
    end
  endtask

  task automatic clear_sb();
    got_q.delete();
    got_cyc_q.delete();
    exp_q.delete();
    last_cyc_q.delete();
  endtask

  // scoreboard: compare every captured output with exp_q, latency 6 after its last beat
  task automatic test_scoreboard_drain(input string name);
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL %s_count: got %0d outputs, expected %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_data[%0d]: got %h, expected %h", name, i, got_q[i], exp_q[i]);
      end
      if (i < last_cyc_q.size()) begin
        checks++;
        if (got_cyc_q[i] - last_cyc_q[i] !== 6) begin
          errors++;
          $display("FAIL %s_latency[%0d]: got %0d cycles, expected 6", name, i,
                   got_cyc_q[i] - last_cyc_q[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", valid_out); end
    checks++;
    if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data: got %h, expected 0", data_out); end
    checks++;
    if (proto_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, expected 0", proto_err); end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_single_beat();
    clear_sb();
    send(1, 1, 16'd1, 16'd2, 16'd3, 16'd4, 16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC);
    gap(12);
    exp_q.push_back(32'hFFF6_000A);
    test_scoreboard_drain("single");
    @(negedge clk);
    checks++;
    if (data_out !== 32'hFFF6_000A) begin
      errors++;
      $display("FAIL single_hold: got %h, expected fff6000a", data_out);
    end
  endtask

  task automatic test_group();
    clear_sb();
    send(1, 0, 16'd10, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0);
    send(0, 0, 16'd5,  16'd5, 16'd5, 16'd5, 16'd2, 16'd0, 16'd0, 16'd0);
    send(0, 1, 16'd7,  16'd8, 16'd9, 16'd6, 16'd0, 16'd1, 16'd1, 16'd1);
    gap(12);
    exp_q.push_back(32'h0006_003C);
    test_scoreboard_drain("group");
  endtask

  task automatic test_bubbles();
    clear_sb();
    send(1, 0, 16'd10, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0);
    gap(2);
    send(0, 0, 16'd5,  16'd5, 16'd5, 16'd5, 16'd2, 16'd0, 16'd0, 16'd0);
    gap(2);
    send(0, 1, 16'd7,  16'd8, 16'd9, 16'd6, 16'd0, 16'd1, 16'd1, 16'd1);
    gap(12);
    exp_q.push_back(32'h0006_003C);
    test_scoreboard_drain("bubbles");
  endtask

  task automatic test_overflow();
    clear_sb();
    // tree overflow, then accumulator overflow
    send(1, 1, 16'h7FFF, 16'h0001, 16'h0, 16'h0, 16'h8000, 16'hFFFF, 16'h0, 16'h0);
    gap(2);
    send(1, 0, 16'h7FFF, 16'h0, 16'h0, 16'h0, 16'h8000, 16'h0, 16'h0, 16'h0);
    send(0, 1, 16'h0001, 16'h0, 16'h0, 16'h0, 16'hFFFF, 16'h0, 16'h0, 16'h0);
    gap(12);
`ifdef TREE_ACC_SAT_EN
    exp_q.push_back(32'h8000_7FFF);
    exp_q.push_back(32'h8000_7FFF);
`else
    exp_q.push_back(32'h7FFF_8000);
    exp_q.push_back(32'h7FFF_8000);
`endif
    test_scoreboard_drain("overflow");
  endtask

  task automatic test_back_to_back();
    clear_sb();
    send(1, 1, 16'd3, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0);
    send(1, 1, 16'd4, 16'd0, 16'd0, 16'd0, 16'd2, 16'd0, 16'd0, 16'd0);
    send(1, 0, 16'd1, 16'd1, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd3);
    send(0, 1, 16'd2, 16'd2, 16'd2, 16'd2, 16'd0, 16'd4, 16'd0, 16'd0);
    gap(12);
    exp_q.push_back(32'h0001_0003);
    exp_q.push_back(32'h0002_0004);
    exp_q.push_back(32'h0007_000C);
    test_scoreboard_drain("b2b");
  endtask

  task automatic test_proto_err();
    clear_sb();
    @(negedge clk);
    checks++;
    if (proto_err !== 1'b0) begin errors++; $display("FAIL perr_before: got %b, expected 0", proto_err); end
    send(1, 0, 16'd5, 16'd0, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0);
    send(1, 0, 16'd7, 16'd0, 16'd0, 16'd0, 16'd2, 16'd0, 16'd0, 16'd0);
    send(0, 1, 16'd1, 16'd0, 16'd0, 16'd0, 16'd3, 16'd0, 16'd0, 16'd0);
    gap(12);
    exp_q.push_back(32'h0005_0008);
    test_scoreboard_drain("perr");
    @(negedge clk);
    checks++;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_set: got %b, expected 1", proto_err); end
    gap(5);
    @(negedge clk);
    checks++;
    if (proto_err !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %b, expected 1", proto_err); end
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (proto_err !== 1'b0) begin errors++; $display("FAIL perr_clear: got %b, expected 0", proto_err); end
  endtask

  task automatic test_reset_mid();
    // open group of 5 dropped by reset, then a single beat of 3
    clear_sb();
    send(1, 0, 16'd5, 16'd0, 16'd0, 16'd0, 16'd5, 16'd0, 16'd0, 16'd0);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(1, 1, 16'd3, 16'd0, 16'd0, 16'd0, 16'd3, 16'd0, 16'd0, 16'd0);
    gap(12);
    exp_q.push_back(32'h0003_0003);
    test_scoreboard_drain("rstmid");

    // partial sum of 9 already in the accumulator is lost; a last-only beat restarts cleanly
    clear_sb();
    send(1, 0, 16'd9, 16'd0, 16'd0, 16'd0, 16'd9, 16'd0, 16'd0, 16'd0);
    gap(4);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 1, 16'd2, 16'd0, 16'd0, 16'd0, 16'd2, 16'd0, 16'd0, 16'd0);
    gap(12);
    exp_q.push_back(32'h0002_0002);
    test_scoreboard_drain("rstacc");

    // finished beat still inside the tree is discarded
    clear_sb();
    send(1, 1, 16'd9, 16'd0, 16'd0, 16'd0, 16'd9, 16'd0, 16'd0, 16'd0);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    gap(12);
    test_scoreboard_drain("rstflight");
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_single_beat();
    test_group();
    test_bubbles();
    test_overflow();
    test_back_to_back();
    test_proto_err();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/channel_in_tree_acc.md
Name: channel_in_tree_acc

Overview:
- Parametrised channel-in reduction block for the TJPU conv datapath.
- Sums CH_NUM input-channel partial results per picture lane through a registered binary adder tree.
- Optionally accumulates the tree result across several beats, delimited by first/last flags.
- Emits one lane-parallel sum with a matching valid, after a configurable alignment delay.

Parameters:
- LANES, `PICTURE_NUM: number of independent picture lanes.
- LANE_W, 2*`WIDTH_DATA_OUT: bits per lane sample, signed two's complement.
- CH_NUM, 4: channels reduced per beat; power of 2, >=2.
- EXTRA_DELAY, 3: register stages after the accumulator, for alignment; >=0.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- valid_in  input  1  beat qualifier.
- first_in  input  1  beat opens a new accumulation (sampled with valid_in).
- last_in  input  1  beat closes the accumulation (sampled with valid_in).
- data_in  input  LANES*CH_NUM*LANE_W  channel c, lane p at [(c*LANES+p)*LANE_W +: LANE_W].
- valid_out  output  1  data_out holds a finished sum.
- data_out  output  LANES*LANE_W  lane p at [p*LANE_W +: LANE_W].
- proto_err  output  1  sticky protocol-violation flag.

Behaviour:
- One clock, clk; synchronous, active-high reset rst. Reset overrides every other input on the same edge.
- Reset values:
  - valid_out=0, data_out=0, proto_err=0.
  - Accumulator = 0, open flag = 0.
  - All pipeline valids = 0; pipeline data = 0.
- Adder tree:
  - L = log2(CH_NUM) levels, one register per level.
  - Each level adds adjacent pairs per lane: channel 2k + channel 2k+1.
  - Result width is LANE_W; wraps modulo 2^LANE_W.
  - valid, first and last travel alongside each level.
  - Bubbles (valid=0) pass through; the tree has no stall and no backpressure.
- Accumulator stage (one register), acting on a valid tree output:
  - If first is set, or open=0: acc = tree, open = 1.
  - Else: acc = acc + tree, per lane, wrapping.
  - If last is set: the stage emits valid, open = 0.
  - Non-last beats produce no output valid.
- Invalid tree beats leave acc and open unchanged.
- Beat with first=1 and last=1: single-beat pass-through of the tree sum.
- first arriving while open=1: the accumulation restarts from this beat and proto_err is set.
- Non-first beat while open=0: treated as first; no error.
- proto_err stays set until rst.
- Delay line: EXTRA_DELAY registers carry data and valid after the accumulator. With EXTRA_DELAY=0 the accumulator register drives the outputs directly.
- data_out holds its last value while valid_out=0.
- Latency: valid_in with last_in at edge n gives valid_out high at edge n+L+1+EXTRA_DELAY. That is 6 cycles for the defaults.
- Throughput: one beat per cycle; back-to-back groups need no gap.
- Reset mid-group: in-flight beats are discarded and the partial sum is lost. A first beat is accepted on the cycle after rst deasserts.

Optional Feature:
- Macro: TREE_ACC_SAT_EN.
- Defined:
  - Every tree adder and the accumulator adder saturate signed to [-2^(LANE_W-1), 2^(LANE_W-1)-1].
  - Saturation is per lane, per stage.
  - Latency is unchanged.
- Undefined: all adds wrap modulo 2^LANE_W and no saturation logic is built.

Test Plan (LANES=2, LANE_W=16, CH_NUM=4, EXTRA_DELAY=3):
- Single beat:
  - Stimulus: rst 2 cycles; one beat first=last=1; lane0 channels 1,2,3,4; lane1 channels -1,-2,-3,-4.
  - Required: valid_out pulses exactly 6 cycles later with lane0=10, lane1=-10 (0xFFF6).
- Three-beat group:
  - Stimulus: beats with lane0 channel sums 10, 20, 30; first on beat 1, last on beat 3; contiguous valid.
  - Required: one valid_out, lane0=60, 6 cycles after beat 3; no output for beats 1-2.
- Bubbles:
  - Stimulus: same group as above with valid_in=0 gaps of 2 cycles between beats.
  - Required: same result 60; the output cycle shifts with the last beat; acc is not disturbed by the gaps.
- Overflow:
  - Stimulus: lane0 channels 0x7FFF, 1, 0, 0, single beat.
  - Required: 0x8000 without TREE_ACC_SAT_EN; 0x7FFF with TREE_ACC_SAT_EN defined.
- Protocol error:
  - Stimulus: first (sum 5), then first (sum 7) without an intervening last, then last (sum 1).
  - Required: output 8; proto_err rises and stays 1 until rst.
- Reset mid-group:
  - Stimulus: first (sum 5); assert rst for 1 cycle; then a first=last beat with sum 3.
  - Required: valid_out=0 during and after reset, with no output of 5; then a single output of 3.
